riscv_multicycle_ctrl: RTL
==========================

Name: riscv_multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle RV32I controller: FSM sequencing fetch/decode/execute/memory/writeback over a shared ALU and unified instruction/data memory.
- Adds all six branch conditions, LUI/AUIPC, JALR, an optional memory-ready handshake, an illegal-opcode trap and cycle/retired-instruction counters.
- Sits beside the multicycle datapath and drives its mux selects and enables; consumes instruction fields and ALU flags from it.

Parameters:
- MEM_WAIT, 1, 1 = honour mem_ready; 0 = treat mem_ready as always 1.
- CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- op  in  7  instruction opcode (IR[6:0]).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  load PC.
- AdrSrc  out  1  0 = PC, 1 = Result.
- IRWrite  out  1  load IR/OldPC.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register-file write.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- trap  out  1  sticky illegal-opcode flag.
- cycle_cnt  out  CNT_W  cycles since reset.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (reset_n = 0 at a clk edge): state = FETCH; trap = 0; counters = 0. Takes effect mid-instruction with no writes that cycle.
- Outputs are Moore from state. Only ImmSrc and ALUControl also decode op/funct3/funct7b5. Unlisted enables are 0; unlisted selects are 00.
- ImmSrc decodes op in every state.
- FETCH: AdrSrc 0, A 00, B 10, add, ResultSrc 10. IRWrite and PCWrite = mem_ready. Stays in FETCH while mem_ready = 0, otherwise goes to DECODE.
- DECODE: A 01, B 01, add (branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - other -> ILLEGAL
- MEMADR: A 10, B 01, add. Goes to MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00. Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite. Retires, then FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite held asserted until mem_ready. Retires on mem_ready, then FETCH.
- EXECR: A 10, B 00. funct3 decoding:
  - 000: add, or sub if funct7b5
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and
  - 101: srl, or sra if funct7b5
  - Next: ALUWB.
- EXECI: A 10, B 01, same funct3 table, except 000 is always add; funct7b5 is used only for 101. Next: ALUWB.
- LUI: B 01, passB -> ALUWB.
- AUIPC: A 01, B 01, add -> ALUWB.
- ALUWB: ResultSrc 00, RegWrite. Retires, then FETCH.
- JAL: A 01, B 10, add, ResultSrc 00, PCWrite -> ALUWB.
- JALR: A 10, B 01, add -> JALR2.
- JALR2: A 01, B 10, add, ResultSrc 00, PCWrite -> ALUWB.
- BRANCH: A 10, B 00, sub, ResultSrc 00. Retires, then FETCH. PCWrite = taken, where taken by funct3 is:
  - 000 Zero, 001 !Zero
  - 100 lt, 101 !lt
  - 110 ltu, 111 !ltu
  - 010/011: never taken
- ILLEGAL: trap = 1, no enables asserted, state held until reset.
- Counters:
  - cycle_cnt increments every non-reset cycle, including ILLEGAL.
  - instret_cnt increments on the retiring cycle defined above.
  - Both wrap modulo 2^CNT_W.
- MEM_WAIT = 0: FETCH, MEMREAD and MEMWRITE each last exactly 1 cycle.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MEM_WAIT = 0 -> FETCH, DECODE, EXECR(ALUControl 0000), ALUWB(RegWrite = 1); 4 cycles, instret_cnt 0->1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> IRWrite/PCWrite pulse only on the ready cycle; MEMWB RegWrite with ResultSrc 01; total 10 cycles.
- Branch sweep, funct3 = 000/001/100/101/110/111 with (Zero, lt, ltu) = (1,0,0) and (0,1,0) -> PCWrite in BRANCH is 1,0,0,1,0,1 and 0,1,1,0,0,1 respectively.
- jalr -> states JALR, JALR2, ALUWB; PCWrite only in FETCH and JALR2; RegWrite only in ALUWB.
- Opcode 0000000 -> ILLEGAL after DECODE; trap = 1, PCWrite/RegWrite/MemWrite stay 0 for 20 cycles; instret_cnt frozen, cycle_cnt advancing.
- reset_n = 0 during MEMWRITE with mem_ready = 0 -> next edge: FETCH, MemWrite 0, trap 0, counters 0; with CNT_W = 4, cycle_cnt wraps 15->0.

Source files
------------

// File: rtl/riscv_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller drives the enables and selects, and the datapath returns instruction fields and ALU flags.
interface riscv_multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    modport master (
        input  op, funct3, funct7b5, Zero, lt, ltu, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );

    modport slave (
        output op, funct3, funct7b5, Zero, lt, ltu, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I controller: a Moore FSM sequencing fetch through writeback.
// It also holds a sticky illegal-opcode trap and the cycle and retired-instruction counters.
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    riscv_multicycle_ctrl_if.master bus,
    output logic               trap,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
        S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_JAL, S_JALR, S_JALR2,
        S_BRANCH, S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       ready;
    logic       taken;
    logic       retire;
    logic       pc_write, ir_write, mem_write, reg_write;
    logic       adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;

    assign ready = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;

    // Shared R/I-type ALU op decode; only R-type turns 000 into sub.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3,
                                           input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return 4'b0111;
            3'b010:  return 4'b0101;
            3'b011:  return 4'b0110;
            3'b100:  return 4'b0100;
            3'b101:  return f7 ? 4'b1001 : 4'b1000;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Next-state sequencing; DECODE dispatches on opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXECR;
                    7'b0010011: state_d = S_EXECI;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR;
                    7'b0110111: state_d = S_LUI;
                    7'b0010111: state_d = S_AUIPC;
                    default:    state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_LUI,
            S_AUIPC,
            S_JAL,
            S_JALR2:    state_d = S_ALUWB;
            S_JALR:     state_d = S_JALR2;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // Branch condition from funct3 and ALU flags; 010/011 never branch.
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = !bus.Zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = !bus.lt;
            3'b110:  taken = bus.ltu;
            3'b111:  taken = !bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src = 3'b000;
        case (bus.op)
            7'b0100011: imm_src = 3'b001;
            7'b1100011: imm_src = 3'b010;
            7'b1101111: imm_src = 3'b011;
            7'b0110111,
            7'b0010111: imm_src = 3'b100;
            default:    imm_src = 3'b000;
        endcase
    end

    // Moore control outputs per state, plus the retire strobe.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = ready;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5, 1'b1);
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5, 1'b0);
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_PASS;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JAL, S_JALR2: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = taken;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Free-running cycle count and retire count, both wrapping.
    always_comb begin
        cycle_d   = cycle_q + CNT_W'(1);
        instret_d = instret_q + CNT_W'(retire);
    end

    // No write strobes leave the block while reset is held.
    assign bus.PCWrite    = pc_write & reset_n;
    assign bus.IRWrite    = ir_write & reset_n;
    assign bus.MemWrite   = mem_write & reset_n;
    assign bus.RegWrite   = reg_write & reset_n;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_ctrl;

    assign trap        = (state_q == S_ILLEGAL);
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule
